reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- 8-entry circular reorder buffer for the Tomasulo core.
- Sits between issue and the architectural register file.
- At issue it allocates the tail entry and exports that tag as ROBTail to the register result status table.
- It captures results broadcast on the 4-lane CDB, supplies operand values by ROB tag to issue, and retires entries in program order, one per cycle, to the register file.

Parameters:
- DEPTH, 8, number of entries (power of two; tag width = log2(DEPTH) = 3).
- DATA_W, 32, result width.
- LANES, 4, CDB lanes. Lane k = CDB[36k+35:36k]: bits [35:4] data, [3] valid, [2:0] tag.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- append  input  1  allocate tail entry this cycle.
- WA  input  4  destination architectural register of the appended instruction.
- ROBTail  output  3  current tail tag (combinational from tail pointer).
- full  output  1  count == 8.
- empty  output  1  count == 0.
- CDB  input  144  result broadcast bus, 4 lanes.
- query  input  6  two ROB tags: [2:0] operand 0, [5:3] operand 1.
- query_ready  output  2  per operand: entry holds result (stored or forwarded from CDB this cycle).
- query_value  output  64  [31:0] operand 0, [63:32] operand 1; 0 when not ready.
- commit_valid  output  1  registered; one entry retired.
- commit_WA  output  4  registered; retired destination register.
- commit_data  output  32  registered; retired value.
- commit_tag  output  3  registered; retired ROB tag.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - head, tail and count (4-bit) = 0.
  - All entry valid/ready = 0.
  - commit_valid = 0, commit_WA = 0, commit_data = 0, commit_tag = 0.
  - Stored WA/value contents are don't-care.
- Entry state: valid, ready, WA[3:0], value[31:0].
- Allocate:
  - On the edge with append && !full: entry[tail] gets valid=1, ready=0, WA=WA; tail = tail+1 mod 8.
  - ROBTail shows the pre-increment tail during the append cycle, so the status table latches the same tag.
  - append while full is ignored: no state change, no error flag.
- Writeback:
  - For each lane with valid=1 whose tag addresses an entry with valid=1 && ready=0: set ready=1 and value=data.
  - If several lanes carry the same tag, the lowest lane index wins.
  - A CDB tag addressing an invalid or already-ready entry is ignored.
  - Same-cycle append and CDB on the tail tag: append wins (ready=0), since the entry was free before the edge.
- Commit:
  - Evaluated on pre-edge state. If entry[head] is valid && ready, on the edge:
    - commit_valid=1 and commit_WA/commit_data/commit_tag take the entry fields.
    - entry[head].valid=0, head = head+1 mod 8.
  - Otherwise commit_valid=0 and the other commit outputs hold their last values.
  - Latency: a result written at edge N commits at edge N+1 at the earliest when at head; commit_valid is visible after N+1.
  - CDB to the head entry in the same cycle does not commit that cycle.
- Count:
  - count += (append accepted) − (commit).
  - Simultaneous accepted append and commit leaves count unchanged.
  - full/empty derive from registered count; wrap of head/tail is natural 3-bit overflow.
- Query (combinational, per operand):
  - If the tagged entry is valid && ready, return its stored value.
  - Else if any CDB lane this cycle is valid and tag-matches an entry that is valid, return that lane's data (lowest lane wins) with ready=1.
  - Else ready=0, value=0.
  - Querying an invalid entry returns ready=0.

Test Plan:
- Reset, then append WA=5 for 3 cycles -> ROBTail 0,1,2; count=3; empty=0; no commit.
- CDB lane 2 {data=0xDEADBEEF, valid, tag=0} after the above -> next cycle commit_valid=1, commit_WA=5, commit_data=0xDEADBEEF, commit_tag=0; head=1.
- CDB writes tag 2 before tag 1 -> no commit until tag 1 is written; then tags 1 and 2 commit on consecutive cycles, in order.
- Fill 8 entries -> full=1; a 9th append is ignored (ROBTail stays 0); write tag 0 -> commit frees a slot; a simultaneous append that cycle is still rejected; the next append takes tag 0.
- query={3'd1,3'd0} with tag 0 ready (0x11) and tag 1 on CDB lane 3 this cycle (0x22) -> query_ready=2'b11, query_value={0x22,0x11}; lanes 0 and 1 both tag 1 with different data -> lane 0 data stored.
- Assert Reset mid-stream with 5 entries pending -> outputs immediately 0, empty=1, ROBTail=0; subsequent CDB traffic is ignored.

Source files
------------

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Bundle of the issue, CDB, operand-query and commit signals
//               that connect the reorder buffer to the rest of the core.
//               slave  = reorder buffer side
//               master = core side (issue / CDB / register file)
//   append, WA        issue-side allocation request and its destination reg
//   ROBTail, full,
//   empty             allocation tag and occupancy flags
//   CDB               LANES x {data, valid, tag} result broadcast
//   query             two ROB tags to read operands for
//   query_ready/value operand availability and values
//   commit_*          registered retirement port to the register file
// Revision    : 1.0  initial release
// ============================================================================
interface reorder_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int LANES  = 4
);
    localparam int c_TAG_W  = $clog2(DEPTH);
    localparam int c_LANE_W = DATA_W + 1 + c_TAG_W;

    logic                      append;
    logic [3:0]                WA;
    logic [c_TAG_W-1:0]        ROBTail;
    logic                      full;
    logic                      empty;
    logic [LANES*c_LANE_W-1:0] CDB;
    logic [2*c_TAG_W-1:0]      query;
    logic [1:0]                query_ready;
    logic [2*DATA_W-1:0]       query_value;
    logic                      commit_valid;
    logic [3:0]                commit_WA;
    logic [DATA_W-1:0]         commit_data;
    logic [c_TAG_W-1:0]        commit_tag;

    modport slave (
        input  append, WA, CDB, query,
        output ROBTail, full, empty, query_ready, query_value,
               commit_valid, commit_WA, commit_data, commit_tag
    );

    modport master (
        output append, WA, CDB, query,
        input  ROBTail, full, empty, query_ready, query_value,
               commit_valid, commit_WA, commit_data, commit_tag
    );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular reorder buffer for the Tomasulo core. Allocates the
//               tail entry at issue, captures CDB results, forwards operand
//               values by ROB tag and retires entries in program order, one
//               per cycle, to the architectural register file.
//   CLK    rising-edge clock
//   Reset  asynchronous, active-high reset
//   bus    reorder_buffer_if.slave (append/WA/ROBTail/full/empty, CDB,
//          query/query_ready/query_value, commit_* outputs)
// Revision    : 1.0  initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  wire logic           CLK,
    input  wire logic           Reset,
    reorder_buffer_if.slave     bus
);
    localparam int c_TAG_W  = $clog2(DEPTH);
    localparam int c_LANE_W = DATA_W + 1 + c_TAG_W;
    localparam int c_CNT_W  = c_TAG_W + 1;

    logic [c_TAG_W-1:0] r_head;
    logic [c_TAG_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_ready;
    logic [3:0]         r_wa    [DEPTH];
    logic [DATA_W-1:0]  r_value [DEPTH];

    logic               r_commit_valid;
    logic [3:0]         r_commit_wa;
    logic [DATA_W-1:0]  r_commit_data;
    logic [c_TAG_W-1:0] r_commit_tag;

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [DEPTH-1:0]   w_hit;
    logic [DATA_W-1:0]  w_hit_data [DEPTH];
    logic [DEPTH-1:0]   w_wb;

    assign w_full = (r_count == c_CNT_W'(DEPTH));
    assign w_push = bus.append && !w_full;
    // Commit looks only at pre-edge state, so a result arriving on the CDB
    // for the head entry retires one cycle later.
    assign w_pop  = r_valid[r_head] && r_ready[r_head];

    // Per-entry CDB match. Lanes are scanned from the highest index down so
    // the lowest-indexed matching lane is the one left standing.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_hit[e]      = 1'b0;
            w_hit_data[e] = '0;
            for (int k = LANES - 1; k >= 0; k--) begin
                if (bus.CDB[k*c_LANE_W + c_TAG_W] &&
                    (bus.CDB[k*c_LANE_W +: c_TAG_W] == c_TAG_W'(e))) begin
                    w_hit[e]      = 1'b1;
                    w_hit_data[e] = bus.CDB[k*c_LANE_W + c_TAG_W + 1 +: DATA_W];
                end
            end
        end
    end

    // Only live, still-waiting entries accept a result. The tail entry is
    // free before an append edge, so a same-cycle CDB hit never lands there.
    assign w_wb = w_hit & r_valid & ~r_ready;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_valid        <= '0;
            r_ready        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_wa    <= '0;
            r_commit_data  <= '0;
            r_commit_tag   <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wb[e]) begin
                    r_ready[e] <= 1'b1;
                end
            end
            // Head and tail coincide with a pop only when full, where the
            // push is blocked, so these two updates never collide.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_commit_valid <= w_pop;
            if (w_pop) begin
                r_commit_wa   <= r_wa[r_head];
                r_commit_data <= r_value[r_head];
                r_commit_tag  <= r_head;
            end
        end
    end

    // Payload storage carries no reset; valid/ready qualify its contents.
    always_ff @(posedge CLK) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_wb[e]) begin
                r_value[e] <= w_hit_data[e];
            end
        end
        if (w_push) begin
            r_wa[r_tail] <= bus.WA;
        end
    end

    generate
        for (genvar o = 0; o < 2; o++) begin : g_query
            logic [c_TAG_W-1:0] w_qtag;
            logic               w_qrdy;
            logic [DATA_W-1:0]  w_qval;

            assign w_qtag = bus.query[o*c_TAG_W +: c_TAG_W];

            always_comb begin
                w_qrdy = 1'b0;
                w_qval = '0;
                if (r_valid[w_qtag] && r_ready[w_qtag]) begin
                    w_qrdy = 1'b1;
                    w_qval = r_value[w_qtag];
                end else if (r_valid[w_qtag] && w_hit[w_qtag]) begin
                    w_qrdy = 1'b1;
                    w_qval = w_hit_data[w_qtag];
                end
            end

            assign bus.query_ready[o]                = w_qrdy;
            assign bus.query_value[o*DATA_W +: DATA_W] = w_qval;
        end
    endgenerate

    assign bus.ROBTail      = r_tail;
    assign bus.full         = w_full;
    assign bus.empty        = (r_count == '0);
    assign bus.commit_valid = r_commit_valid;
    assign bus.commit_WA    = r_commit_wa;
    assign bus.commit_data  = r_commit_data;
    assign bus.commit_tag   = r_commit_tag;
endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. A queue-based model
//               of the in-flight instruction window predicts flags, operand
//               queries and retirements; expected retirements are queued and
//               matched by an independent commit monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;
    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    reorder_buffer_if #(.DEPTH(8), .DATA_W(32), .LANES(4)) bus ();

    reorder_buffer #(.DEPTH(8), .DATA_W(32), .LANES(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // In-flight window, oldest first; an entry exists iff it is allocated.
    typedef struct {
        int         tag;
        logic [3:0] wa;
        bit         rdy;
        logic [31:0] val;
    } ent_t;
    ent_t rob[$];
    int   tail_tag = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  wa;
        logic [31:0] data;
        int          tag;
    } cmt_t;
    cmt_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [143:0] lane_at(input int k, input logic [31:0] d, input int t);
        logic [143:0] v;
        v = {108'b0, d, 1'b1, 3'(t)};
        return v << (36 * k);
    endfunction

    function automatic int find(input int t);
        for (int i = 0; i < rob.size(); i++)
            if (rob[i].tag == t) return i;
        return -1;
    endfunction

    task automatic model_query(input int t, input logic [143:0] cdb,
                               output bit r, output logic [31:0] v);
        int i;
        i = find(t);
        r = 1'b0;
        v = '0;
        if (i >= 0) begin
            if (rob[i].rdy) begin
                r = 1'b1;
                v = rob[i].val;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (!r && cdb[36*k+3] && (int'(cdb[36*k +: 3]) == t)) begin
                        r = 1'b1;
                        v = cdb[36*k+4 +: 32];
                    end
                end
            end
        end
    endtask

    // One clock of stimulus: drive, check combinational outputs, advance model.
    task automatic cycle(input bit app, input logic [3:0] wa,
                         input logic [143:0] cdb, input logic [5:0] qry);
        bit          r0, r1;
        logic [31:0] v0, v1;
        int          n, i;
        bit          do_commit;
        @(negedge CLK);
        #1;
        bus.append = app;
        bus.WA     = wa;
        bus.CDB    = cdb;
        bus.query  = qry;
        #1;
        n = rob.size();
        chk("ROBTail", 64'(bus.ROBTail), 64'(tail_tag));
        chk("full",    64'(bus.full),    64'(n == 8));
        chk("empty",   64'(bus.empty),   64'(n == 0));
        model_query(int'(qry[2:0]), cdb, r0, v0);
        model_query(int'(qry[5:3]), cdb, r1, v1);
        chk("query_ready", 64'(bus.query_ready), 64'({r1, r0}));
        chk("query_value", bus.query_value, {v1, v0});

        do_commit = (n > 0) && rob[0].rdy;
        if (do_commit)
            sb.push_back('{cyc + 1, rob[0].wa, rob[0].val, rob[0].tag});
        for (int k = 0; k < 4; k++) begin
            if (cdb[36*k+3]) begin
                i = find(int'(cdb[36*k +: 3]));
                if (i >= 0 && !rob[i].rdy) begin
                    rob[i].rdy = 1'b1;
                    rob[i].val = cdb[36*k+4 +: 32];
                end
            end
        end
        if (do_commit) void'(rob.pop_front());
        if (app && n < 8) begin
            rob.push_back('{tail_tag, wa, 1'b0, 32'h0});
            tail_tag = (tail_tag + 1) % 8;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'h0, 144'h0, 6'h0);
    endtask

    // Asserts Reset mid-cycle and checks the outputs clear without a clock.
    task automatic do_reset();
        @(negedge CLK);
        #1;
        Reset      = 1'b1;
        bus.append = 1'b0;
        bus.CDB    = '0;
        #1;
        chk("rst_commit_valid", 64'(bus.commit_valid), 64'h0);
        chk("rst_commit_WA",    64'(bus.commit_WA),    64'h0);
        chk("rst_commit_data",  64'(bus.commit_data),  64'h0);
        chk("rst_commit_tag",   64'(bus.commit_tag),   64'h0);
        chk("rst_empty",        64'(bus.empty),        64'h1);
        chk("rst_full",         64'(bus.full),         64'h0);
        chk("rst_ROBTail",      64'(bus.ROBTail),      64'h0);
        rob.delete();
        sb.delete();
        tail_tag = 0;
        @(negedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    // Commit monitor: pairs every retirement with the oldest expected one.
    initial begin
        cmt_t e;
        forever begin
            @(negedge CLK);
            if (bus.commit_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL commit_unexpected: got tag %0d, expected no commit (cycle %0d)",
                             bus.commit_tag, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("commit_cycle", 64'(cyc),             64'(e.cyc));
                    chk("commit_WA",    64'(bus.commit_WA),   64'(e.wa));
                    chk("commit_data",  64'(bus.commit_data), 64'(e.data));
                    chk("commit_tag",   64'(bus.commit_tag),  64'(e.tag));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk("commit_valid", 64'(bus.commit_valid), 64'h1);
            end
        end
    end

    initial begin
        logic [143:0] cdb;
        bus.append = 1'b0;
        bus.WA     = '0;
        bus.CDB    = '0;
        bus.query  = '0;
        do_reset();

        // Three appends, then retire tag 0 from CDB lane 2.
        repeat (3) cycle(1'b1, 4'd5, 144'h0, 6'h0);
        cycle(1'b0, 4'd0, 144'h0, {3'd1, 3'd0});
        cycle(1'b0, 4'd0, lane_at(2, 32'hDEADBEEF, 0), 6'h0);
        idle(2);

        // Out-of-order writeback: tag 2 before tag 1.
        cycle(1'b0, 4'd0, lane_at(0, 32'h2222, 2), {3'd2, 3'd1});
        idle(2);
        cycle(1'b0, 4'd0, lane_at(1, 32'h1111, 1), {3'd2, 3'd1});
        idle(3);

        // Fill, overflow append, commit with a simultaneous rejected append.
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1'b1, 4'(i), 144'h0, 6'h0);
        cycle(1'b1, 4'd7, lane_at(0, 32'hA0, 0), 6'h0);
        repeat (3) cycle(1'b1, 4'd3, 144'h0, 6'h0);

        // Operand query: stored result plus same-cycle CDB forwarding.
        do_reset();
        cycle(1'b1, 4'd1, 144'h0, 6'h0);
        cycle(1'b1, 4'd2, 144'h0, 6'h0);
        cycle(1'b0, 4'd0, lane_at(0, 32'h11, 0), 6'h0);
        cycle(1'b0, 4'd0, lane_at(3, 32'h22, 1), {3'd1, 3'd0});
        idle(3);

        // Two lanes on the same tag: lane 0 must win.
        do_reset();
        cycle(1'b1, 4'd8, 144'h0, 6'h0);
        cycle(1'b1, 4'd9, 144'h0, 6'h0);
        cycle(1'b0, 4'd0, lane_at(0, 32'hAAAA, 1) | lane_at(1, 32'hBBBB, 1), {3'd1, 3'd1});
        cycle(1'b0, 4'd0, lane_at(2, 32'h33, 0), {3'd1, 3'd0});
        idle(3);

        // Reset with five entries in flight, then stale CDB traffic.
        do_reset();
        repeat (5) cycle(1'b1, 4'd4, 144'h0, 6'h0);
        cycle(1'b0, 4'd0, lane_at(1, 32'h55, 1), 6'h0);
        do_reset();
        cycle(1'b0, 4'd0, lane_at(0, 32'h1, 0) | lane_at(1, 32'h2, 1) | lane_at(2, 32'h3, 2),
              {3'd1, 3'd0});
        cycle(1'b0, 4'd0, lane_at(3, 32'h4, 3), {3'd4, 3'd3});
        idle(3);

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) do_reset();
            cdb = '0;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 1) == 1)
                    cdb = cdb | lane_at(k, $urandom, int'($urandom_range(0, 7)));
            cycle(($urandom_range(0, 9) < ((i < 1500) ? 8 : 5)), 4'($urandom), cdb, 6'($urandom));
        end
        idle(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
